// File: rtl/fibonacci_sequencer_if.sv
// Command/config and status bundle between the wishbone register logic (master)
// and the fibonacci run controller (slave).
interface fibonacci_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             cmd_start;
   logic             cmd_stop;
   logic             cmd_step;
   logic [2:0]       cfg_div_sel;
   logic [CNT_W-1:0] cfg_count;
   logic             fib_clear;
   logic             fib_en;
   logic [CNT_W-1:0] steps_done;
   logic             busy;
   logic             done_irq;
   logic [1:0]       state_o;

   modport master (
      output cmd_start, cmd_stop, cmd_step, cfg_div_sel, cfg_count,
      input  fib_clear, fib_en, steps_done, busy, done_irq, state_o
   );

   modport slave (
      input  cmd_start, cmd_stop, cmd_step, cfg_div_sel, cfg_count,
      output fib_clear, fib_en, steps_done, busy, done_irq, state_o
   );
endinterface

// File: rtl/fibonacci_sequencer.sv
// Run controller for the fibonacci datapath: clear pulse, then a programmed number
// of step enables at a prescaled rate (single clock, enable based), then DONE.
// Build option FIB_SEQ_AUTORELOAD_EN: DONE immediately re-enters CLEAR with the
// latched config, rerunning until stop.
//
// state | meaning
// IDLE  | waiting for start; manual steps allowed
// CLEAR | one cycle, fib_clear asserted, config latched
// RUN   | prescaler running, fib_en on each terminal count
// DONE  | run complete (done_irq on entry); manual steps allowed
module fibonacci_sequencer #(
   parameter int DIV_SHIFT = 4,
   parameter int MAX_SEL   = 5,
   parameter int CNT_W     = 16
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   fibonacci_sequencer_if.slave  seq_if
);
   localparam int PRE_W = (DIV_SHIFT * MAX_SEL > 0) ? DIV_SHIFT * MAX_SEL : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PRE_W-1:0] pre_nxt;
   logic [PRE_W-1:0] div_m1;
   logic [2:0]       sel_q, sel_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic             fib_clear_q, fib_clear_d;
   logic             fib_en_q, fib_en_d;
   logic             done_irq_q, done_irq_d;
   logic             busy_q, busy_d;

   // Terminal prescaler value: 2^(DIV_SHIFT*sel)-1 as a run of low ones (sel is pre-clamped).
   always_comb begin
      div_m1 = '0;
      for (int i = 0; i < PRE_W; i++) begin
         div_m1[i] = (i < DIV_SHIFT * int'(sel_q));
      end
   end

   // Command arbitration (stop > start > step) and state/output next values.
   always_comb begin
      state_d     = state_q;
      pre_d       = pre_q;
      sel_d       = sel_q;
      count_d     = count_q;
      steps_d     = steps_q;
      fib_clear_d = 1'b0;
      fib_en_d    = 1'b0;
      done_irq_d  = 1'b0;
      pre_nxt     = (pre_q == div_m1) ? '0 : pre_q + 1'b1;

      if (seq_if.cmd_stop) begin
         state_d = ST_IDLE;
         pre_d   = '0;
      end else if (seq_if.cmd_start) begin
         state_d     = ST_CLEAR;
         fib_clear_d = 1'b1;
         steps_d     = '0;
         pre_d       = '0;
         count_d     = seq_if.cfg_count;
         sel_d       = (seq_if.cfg_div_sel > 3'(MAX_SEL)) ? 3'(MAX_SEL) : seq_if.cfg_div_sel;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (seq_if.cmd_step) begin
                  fib_en_d = 1'b1;
                  steps_d  = steps_q + 1'b1;
               end
            end
            ST_DONE: begin
`ifdef FIB_SEQ_AUTORELOAD_EN
               state_d     = ST_CLEAR;
               fib_clear_d = 1'b1;
               steps_d     = '0;
               pre_d       = '0;
`else
               if (seq_if.cmd_step) begin
                  fib_en_d = 1'b1;
                  steps_d  = steps_q + 1'b1;
               end
`endif
            end
            ST_CLEAR: begin
               pre_d = '0;
               if (count_q == '0) begin
                  state_d    = ST_DONE;
                  done_irq_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  // Undivided rate must pulse in the very first RUN cycle.
                  if (div_m1 == '0) begin
                     fib_en_d = 1'b1;
                     steps_d  = steps_q + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (fib_en_q && (steps_q == count_q)) begin
                  state_d    = ST_DONE;
                  done_irq_d = 1'b1;
                  pre_d      = '0;
               end else begin
                  pre_d = pre_nxt;
                  if (pre_nxt == div_m1) begin
                     fib_en_d = 1'b1;
                     steps_d  = steps_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d == ST_CLEAR) || (state_d == ST_RUN);
   end

   // State and registered outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_IDLE;
         pre_q       <= '0;
         sel_q       <= '0;
         count_q     <= '0;
         steps_q     <= '0;
         fib_clear_q <= 1'b0;
         fib_en_q    <= 1'b0;
         done_irq_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         sel_q       <= sel_d;
         count_q     <= count_d;
         steps_q     <= steps_d;
         fib_clear_q <= fib_clear_d;
         fib_en_q    <= fib_en_d;
         done_irq_q  <= done_irq_d;
         busy_q      <= busy_d;
      end
   end

   assign seq_if.fib_clear  = fib_clear_q;
   assign seq_if.fib_en     = fib_en_q;
   assign seq_if.steps_done = steps_q;
   assign seq_if.busy       = busy_q;
   assign seq_if.done_irq   = done_irq_q;
   assign seq_if.state_o    = state_q;
endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Directed bench for fibonacci_sequencer; expected values hand-derived from the cycle timeline.
module tb_fibonacci_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   en_seen;

   fibonacci_sequencer_if #(.CNT_W(16)) sif ();

   fibonacci_sequencer #(.DIV_SHIFT(4), .MAX_SEL(5), .CNT_W(16)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .seq_if   (sif.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // After return the bench sits in the CLEAR cycle (k+1).
   task automatic do_start(input logic [2:0] sel, input logic [15:0] cnt);
      sif.cfg_div_sel = sel;
      sif.cfg_count   = cnt;
      sif.cmd_start   = 1'b1;
      tick();
      sif.cmd_start   = 1'b0;
   endtask

   task automatic do_stop();
      sif.cmd_stop = 1'b1;
      tick();
      sif.cmd_stop = 1'b0;
   endtask

   initial begin
      sif.cmd_start   = 1'b0;
      sif.cmd_stop    = 1'b0;
      sif.cmd_step    = 1'b0;
      sif.cfg_div_sel = 3'd0;
      sif.cfg_count   = 16'd0;

      // reset
      tick();
      tick();
      check_val("rst_state", 32'(sif.state_o), 32'd0);
      check_val("rst_clear", 32'(sif.fib_clear), 32'd0);
      check_val("rst_en", 32'(sif.fib_en), 32'd0);
      check_val("rst_irq", 32'(sif.done_irq), 32'd0);
      check_val("rst_busy", 32'(sif.busy), 32'd0);
      check_val("rst_steps", 32'(sif.steps_done), 32'd0);
      rst = 1'b0;

      // sel=0 count=5
      do_start(3'd0, 16'd5);
      check_val("s0_clr_state", 32'(sif.state_o), 32'd1);
      check_val("s0_clr_pulse", 32'(sif.fib_clear), 32'd1);
      check_val("s0_clr_en", 32'(sif.fib_en), 32'd0);
      check_val("s0_clr_busy", 32'(sif.busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("s0_run_en", 32'(sif.fib_en), 32'd1);
         check_val("s0_run_clr", 32'(sif.fib_clear), 32'd0);
         check_val("s0_run_steps", 32'(sif.steps_done), 32'(i + 1));
         check_val("s0_run_irq", 32'(sif.done_irq), 32'd0);
         check_val("s0_run_state", 32'(sif.state_o), 32'd2);
      end
      tick();
      check_val("s0_done_state", 32'(sif.state_o), 32'd3);
      check_val("s0_done_irq", 32'(sif.done_irq), 32'd1);
      check_val("s0_done_en", 32'(sif.fib_en), 32'd0);
      check_val("s0_done_steps", 32'(sif.steps_done), 32'd5);
      check_val("s0_done_busy", 32'(sif.busy), 32'd0);
      tick();
      check_val("s0_irq_once", 32'(sif.done_irq), 32'd0);
      do_stop();

      // sel=1 count=3: enables on RUN cycles 15, 31, 47; DONE on 48
      do_start(3'd1, 16'd3);
      for (int c = 0; c <= 60; c++) begin
         tick();
         check_val("s1_en", 32'(sif.fib_en), 32'((c == 15) || (c == 31) || (c == 47)));
         check_val("s1_irq", 32'(sif.done_irq), 32'(c == 48));
      end
      do_stop();

      // sel=7 clamps to 5: no enable within 5000 cycles
      do_start(3'd7, 16'd1);
      en_seen = 0;
      for (int c = 0; c < 5000; c++) begin
         tick();
         if (sif.fib_en) en_seen++;
      end
      check_val("s7_no_en", 32'(en_seen), 32'd0);
      check_val("s7_state", 32'(sif.state_o), 32'd2);
      do_stop();

      // stop after second enable
      do_start(3'd0, 16'd100);
      tick();
      tick();
      check_val("stop_pre_steps", 32'(sif.steps_done), 32'd2);
      do_stop();
      check_val("stop_state", 32'(sif.state_o), 32'd0);
      check_val("stop_en", 32'(sif.fib_en), 32'd0);
      check_val("stop_steps", 32'(sif.steps_done), 32'd2);
      check_val("stop_busy", 32'(sif.busy), 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         check_val("stop_no_irq", 32'(sif.done_irq), 32'd0);
         check_val("stop_hold", 32'(sif.steps_done), 32'd2);
      end

      // count=0
      do_start(3'd0, 16'd0);
      check_val("c0_clear", 32'(sif.fib_clear), 32'd1);
      tick();
      check_val("c0_state", 32'(sif.state_o), 32'd3);
      check_val("c0_irq", 32'(sif.done_irq), 32'd1);
      check_val("c0_en", 32'(sif.fib_en), 32'd0);
      check_val("c0_steps", 32'(sif.steps_done), 32'd0);
      // step + stop together: stop wins
      sif.cmd_step = 1'b1;
      sif.cmd_stop = 1'b1;
      tick();
      sif.cmd_step = 1'b0;
      sif.cmd_stop = 1'b0;
      check_val("ss_state", 32'(sif.state_o), 32'd0);
      check_val("ss_en", 32'(sif.fib_en), 32'd0);
      check_val("ss_steps", 32'(sif.steps_done), 32'd0);

      // two consecutive manual steps in IDLE
      sif.cmd_step = 1'b1;
      tick();
      check_val("st1_en", 32'(sif.fib_en), 32'd1);
      check_val("st1_steps", 32'(sif.steps_done), 32'd1);
      check_val("st1_state", 32'(sif.state_o), 32'd0);
      tick();
      sif.cmd_step = 1'b0;
      check_val("st2_en", 32'(sif.fib_en), 32'd1);
      check_val("st2_steps", 32'(sif.steps_done), 32'd2);
      tick();
      check_val("st3_en", 32'(sif.fib_en), 32'd0);
      check_val("st3_steps", 32'(sif.steps_done), 32'd2);

      // step in RUN ignored, then restart from RUN
      do_start(3'd1, 16'd3);
      tick();
      sif.cmd_step = 1'b1;
      tick();
      sif.cmd_step = 1'b0;
      check_val("strun_en", 32'(sif.fib_en), 32'd0);
      check_val("strun_steps", 32'(sif.steps_done), 32'd0);
      do_start(3'd0, 16'd1);
      check_val("rs_state", 32'(sif.state_o), 32'd1);
      check_val("rs_clear", 32'(sif.fib_clear), 32'd1);
      tick();
      check_val("rs_en", 32'(sif.fib_en), 32'd1);
      check_val("rs_steps", 32'(sif.steps_done), 32'd1);
      tick();
      check_val("rs_done", 32'(sif.state_o), 32'd3);
      check_val("rs_irq", 32'(sif.done_irq), 32'd1);

`ifdef FIB_SEQ_AUTORELOAD_EN
      // count=2: clear, en, en, irq repeating
      do_stop();
      do_start(3'd0, 16'd2);
      for (int c = 0; c < 12; c++) begin
         if (c != 0) tick();
         check_val("ar_clear", 32'(sif.fib_clear), 32'((c % 4) == 0));
         check_val("ar_en", 32'(sif.fib_en), 32'(((c % 4) == 1) || ((c % 4) == 2)));
         check_val("ar_irq", 32'(sif.done_irq), 32'((c % 4) == 3));
      end
      do_stop();
      check_val("ar_stop", 32'(sif.state_o), 32'd0);
`else
      // DONE is held without commands
      for (int c = 0; c < 5; c++) begin
         tick();
         check_val("hold_state", 32'(sif.state_o), 32'd3);
         check_val("hold_irq", 32'(sif.done_irq), 32'd0);
         check_val("hold_en", 32'(sif.fib_en), 32'd0);
      end
      // manual step in DONE
      sif.cmd_step = 1'b1;
      tick();
      sif.cmd_step = 1'b0;
      check_val("dstep_en", 32'(sif.fib_en), 32'd1);
      check_val("dstep_steps", 32'(sif.steps_done), 32'd2);
      check_val("dstep_state", 32'(sif.state_o), 32'd3);
`endif

      // reset mid-run wins over a start
      do_start(3'd0, 16'd50);
      tick();
      rst = 1'b1;
      sif.cmd_start = 1'b1;
      tick();
      sif.cmd_start = 1'b0;
      rst = 1'b0;
      check_val("mrst_state", 32'(sif.state_o), 32'd0);
      check_val("mrst_steps", 32'(sif.steps_done), 32'd0);
      check_val("mrst_clear", 32'(sif.fib_clear), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
